regfile_2r1w: RTL and testbench



---
 rtl/regfile_2r1w.sv | 136 +++++++++++++
 tb/tb_regfile_2r1w.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: two combinational read ports, one synchronous write port,
// a per-register busy scoreboard, and a clear sequencer that zeroes every
// register after reset.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
module regfile_2r1w #(
  parameter int unsigned REG_ID_LEN = 4,
  parameter int unsigned REG_SIZE   = 64,
  parameter int unsigned ZERO_REG   = 0,
  parameter int unsigned DEBUG      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready,
  input  logic [REG_ID_LEN-1:0] ra_id,
  output logic [REG_SIZE-1:0]   ra_out,
  output logic                  ra_busy,
  input  logic [REG_ID_LEN-1:0] rb_id,
  output logic [REG_SIZE-1:0]   rb_out,
  output logic                  rb_busy,
  input  logic                  write,
  input  logic [REG_ID_LEN-1:0] w_id,
  input  logic [REG_SIZE-1:0]   w_value,
  input  logic                  reserve,
  input  logic [REG_ID_LEN-1:0] rs_id
);

  localparam int unsigned REGS_COUNT = 1 << REG_ID_LEN;
  localparam int unsigned IDX_W      = REG_ID_LEN + 1;
  localparam bit          ZR         = (ZERO_REG != 0);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [REG_SIZE-1:0]   regs [REGS_COUNT];
  logic [REGS_COUNT-1:0] busy_q;
  logic                  run;
  logic                  wr_ok;
  logic                  rs_ok;

  assign run   = (state_q == READY);
  assign ready = run;
  // Register 0 is hardwired when ZERO_REG is set, so its writes/reserves drop.
  assign wr_ok = run && write   && !(ZR && (w_id  == '0));
  assign rs_ok = run && reserve && !(ZR && (rs_id == '0));

  // State and clear-index register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Clear sequencer: walk every index once, then go ready.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == CLEAR) begin
      idx_d = idx_q + IDX_W'(1);
      if (idx_q == IDX_W'(REGS_COUNT - 1)) begin
        state_d = READY;
      end
    end
  end

  // Busy scoreboard: write retires the producer, reserve (applied last) wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      if (wr_ok) begin
        busy_q[w_id] <= 1'b0;
      end
      if (rs_ok) begin
        busy_q[rs_id] <= 1'b1;
      end
    end
  end

  // Register storage: zeroed by the sequencer, then written by writeback.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        regs[idx_q[REG_ID_LEN-1:0]] <= '0;
      end else if (wr_ok) begin
        regs[w_id] <= w_value;
      end
    end
  end

  // Read port A: stored state, optionally forwarded from the write port.
  always_comb begin
    ra_out  = '0;
    ra_busy = 1'b0;
    if (run && !(ZR && (ra_id == '0))) begin
      ra_out  = regs[ra_id];
      ra_busy = busy_q[ra_id];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (w_id == ra_id)) begin
        ra_out  = w_value;
        ra_busy = 1'b0;
      end
`endif
    end
  end

  // Read port B: same behaviour as port A.
  always_comb begin
    rb_out  = '0;
    rb_busy = 1'b0;
    if (run && !(ZR && (rb_id == '0))) begin
      rb_out  = regs[rb_id];
      rb_busy = busy_q[rb_id];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (w_id == rb_id)) begin
        rb_out  = w_value;
        rb_busy = 1'b0;
      end
`endif
    end
  end

  // Debug trace of committed writes.
  if (DEBUG != 0) begin : g_debug
    always_ff @(posedge clk) begin
      if (!rst && wr_ok) begin
        $write("RF: r%0d <= 0x%0h\n", w_id, w_value);
      end
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w (default build and REGFILE_BYPASS_EN build).
module tb_regfile_2r1w;

  localparam int unsigned IDW = 4;
  localparam int unsigned DW  = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           ready, z_ready;
  logic [IDW-1:0] ra_id = '0, rb_id = '0, w_id = '0, rs_id = '0;
  logic [DW-1:0]  ra_out, rb_out, z_ra_out, z_rb_out;
  logic           ra_busy, rb_busy, z_ra_busy, z_rb_busy;
  logic           write = 1'b0, reserve = 1'b0;
  logic [DW-1:0]  w_value = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_2r1w #(.REG_ID_LEN(IDW), .REG_SIZE(DW), .ZERO_REG(0), .DEBUG(0)) u_dut (
    .clk(clk), .rst(rst), .ready(ready),
    .ra_id(ra_id), .ra_out(ra_out), .ra_busy(ra_busy),
    .rb_id(rb_id), .rb_out(rb_out), .rb_busy(rb_busy),
    .write(write), .w_id(w_id), .w_value(w_value),
    .reserve(reserve), .rs_id(rs_id)
  );

  regfile_2r1w #(.REG_ID_LEN(IDW), .REG_SIZE(DW), .ZERO_REG(1), .DEBUG(0)) u_dut_z (
    .clk(clk), .rst(rst), .ready(z_ready),
    .ra_id(ra_id), .ra_out(z_ra_out), .ra_busy(z_ra_busy),
    .rb_id(rb_id), .rb_out(z_rb_out), .rb_busy(z_rb_busy),
    .write(write), .w_id(w_id), .w_value(w_value),
    .reserve(reserve), .rs_id(rs_id)
  );

  typedef struct {
    logic           wr;
    logic [IDW-1:0] wid;
    logic [DW-1:0]  wv;
    logic           rs;
    logic [IDW-1:0] rsid;
    logic [IDW-1:0] ra;
    logic [IDW-1:0] rb;
    logic [DW-1:0]  ea;
    logic [DW-1:0]  eb;
    logic           eab;
    logic           ebb;
  } vec_t;

  typedef struct {
    logic [DW-1:0] ra;
    logic [DW-1:0] rb;
    logic          rab;
    logic          rbb;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];

  task automatic chk64(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%b required=%b", nm, act, req);
    end
  endtask

  task automatic add(input logic wr, input logic [IDW-1:0] wid, input logic [DW-1:0] wv,
                     input logic rs, input logic [IDW-1:0] rsid,
                     input logic [IDW-1:0] ra, input logic [IDW-1:0] rb,
                     input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                     input logic eab, input logic ebb);
    vec_t v;
    v.wr = wr; v.wid = wid; v.wv = wv; v.rs = rs; v.rsid = rsid;
    v.ra = ra; v.rb = rb; v.ea = ea; v.eb = eb; v.eab = eab; v.ebb = ebb;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count rst-low edges until ready rises; 0 means it never rose in the budget.
  task automatic wait_ready(output int rise_at);
    rise_at = 0;
    for (int e = 1; e <= 40 && rise_at == 0; e++) begin
      tick();
      if (ready) rise_at = e;
    end
  endtask

  task automatic idle_inputs();
    write = 1'b0; reserve = 1'b0; w_id = '0; rs_id = '0; w_value = '0;
  endtask

  localparam logic [DW-1:0] ALL1 = '1;

  initial begin
    int   rise;
    exp_t e;
    exp_t g;

    // Expected reads are for the cycle's own ids, before that cycle's edge.
    add(1'b1, 4'd3,  64'hAA,   1'b0, 4'd0,  4'd3,  4'd5,  64'h0,    64'h0,    1'b0, 1'b0);
    add(1'b1, 4'd5,  64'h55,   1'b0, 4'd0,  4'd3,  4'd5,  64'hAA,   64'h0,    1'b0, 1'b0);
    add(1'b0, 4'd0,  64'h0,    1'b0, 4'd0,  4'd3,  4'd5,  64'hAA,   64'h55,   1'b0, 1'b0);
    add(1'b0, 4'd0,  64'h0,    1'b0, 4'd0,  4'd3,  4'd3,  64'hAA,   64'hAA,   1'b0, 1'b0);
    add(1'b0, 4'd0,  64'h0,    1'b1, 4'd7,  4'd7,  4'd3,  64'h0,    64'hAA,   1'b0, 1'b0);
    add(1'b0, 4'd0,  64'h0,    1'b0, 4'd0,  4'd7,  4'd7,  64'h0,    64'h0,    1'b1, 1'b1);
    add(1'b1, 4'd7,  64'h1234, 1'b0, 4'd0,  4'd7,  4'd5,  64'h0,    64'h55,   1'b1, 1'b0);
    add(1'b0, 4'd0,  64'h0,    1'b0, 4'd0,  4'd7,  4'd7,  64'h1234, 64'h1234, 1'b0, 1'b0);
    add(1'b1, 4'd7,  64'hBEEF, 1'b1, 4'd7,  4'd7,  4'd3,  64'h1234, 64'hAA,   1'b0, 1'b0);
    add(1'b0, 4'd0,  64'h0,    1'b0, 4'd0,  4'd7,  4'd7,  64'hBEEF, 64'hBEEF, 1'b1, 1'b1);
    add(1'b1, 4'd0,  64'hFF,   1'b0, 4'd0,  4'd0,  4'd15, 64'h0,    64'h0,    1'b0, 1'b0);
    add(1'b1, 4'd15, ALL1,     1'b0, 4'd0,  4'd0,  4'd15, 64'hFF,   64'h0,    1'b0, 1'b0);
    add(1'b0, 4'd0,  64'h0,    1'b1, 4'd15, 4'd15, 4'd0,  ALL1,     64'hFF,   1'b0, 1'b0);
    add(1'b1, 4'd2,  64'h42,   1'b0, 4'd0,  4'd2,  4'd15, 64'h0,    ALL1,     1'b0, 1'b1);
    add(1'b0, 4'd0,  64'h0,    1'b0, 4'd0,  4'd2,  4'd2,  64'h42,   64'h42,   1'b0, 1'b0);

    // Reset held for two edges.
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk1("reset ready", ready, 1'b0);
    chk64("reset ra_out", ra_out, '0);
    chk64("reset rb_out", rb_out, '0);
    chk1("reset ra_busy", ra_busy, 1'b0);
    chk1("reset rb_busy", rb_busy, 1'b0);

    // Release; attempt writes/reserves during the clear, which must be ignored.
    rst = 1'b0;
    write = 1'b1; w_id = 4'd3; w_value = 64'hDEAD; reserve = 1'b1; rs_id = 4'd3;
    rise = 0;
    for (int e = 1; e <= 40 && rise == 0; e++) begin
      tick();
      if (e == 8) idle_inputs();
      if (ready) rise = e;
    end
    chk64("clear latency", 64'(rise), 64'd16);

    // Every register reads zero and idle after the clear.
    for (int i = 0; i < 16; i++) begin
      ra_id = 4'(i);
      rb_id = 4'(15 - i);
      @(negedge clk);
      chk64($sformatf("clear ra r%0d", i), ra_out, '0);
      chk64($sformatf("clear rb r%0d", 15 - i), rb_out, '0);
      chk1($sformatf("clear busy r%0d", i), ra_busy, 1'b0);
      tick();
    end

    // Table-driven vectors through the scoreboard queue.
    foreach (vecs[i]) begin
      write = vecs[i].wr; w_id = vecs[i].wid; w_value = vecs[i].wv;
      reserve = vecs[i].rs; rs_id = vecs[i].rsid;
      ra_id = vecs[i].ra; rb_id = vecs[i].rb;
      e.ra = vecs[i].ea; e.rb = vecs[i].eb; e.rab = vecs[i].eab; e.rbb = vecs[i].ebb;
`ifdef REGFILE_BYPASS_EN
      if (vecs[i].wr && vecs[i].wid == vecs[i].ra) begin e.ra = vecs[i].wv; e.rab = 1'b0; end
      if (vecs[i].wr && vecs[i].wid == vecs[i].rb) begin e.rb = vecs[i].wv; e.rbb = 1'b0; end
`endif
      sbq.push_back(e);
      @(negedge clk);
      g = sbq.pop_front();
      chk64($sformatf("vec%0d ra_out", i), ra_out, g.ra);
      chk64($sformatf("vec%0d rb_out", i), rb_out, g.rb);
      chk1($sformatf("vec%0d ra_busy", i), ra_busy, g.rab);
      chk1($sformatf("vec%0d rb_busy", i), rb_busy, g.rbb);
      tick();
    end
    idle_inputs();

    // Write + reserve of r0: normal file keeps both, ZERO_REG file drops both.
    write = 1'b1; w_id = 4'd0; w_value = 64'h1FF; reserve = 1'b1; rs_id = 4'd0;
    ra_id = 4'd0; rb_id = 4'd3;
    @(negedge clk);
    chk64("zreg same-cycle ra_out", z_ra_out, '0);
    chk1("zreg same-cycle ra_busy", z_ra_busy, 1'b0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk64("zreg ra_out", z_ra_out, '0);
    chk1("zreg ra_busy", z_ra_busy, 1'b0);
    chk64("zreg rb_out r3", z_rb_out, 64'hAA);
    chk64("r0 ra_out", ra_out, 64'h1FF);
    chk1("r0 ra_busy", ra_busy, 1'b1);
    tick();

    // Write r2 while both ports read it: forwarded only in the bypass build.
    write = 1'b1; w_id = 4'd2; w_value = 64'h99; ra_id = 4'd2; rb_id = 4'd2;
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    chk64("bypass ra same-cycle", ra_out, 64'h99);
    chk64("bypass rb same-cycle", rb_out, 64'h99);
`else
    chk64("nobypass ra same-cycle", ra_out, 64'h42);
    chk64("nobypass rb same-cycle", rb_out, 64'h42);
`endif
    tick();
    idle_inputs();
    @(negedge clk);
    chk64("write r2 next-cycle", ra_out, 64'h99);
    tick();

    // Reset mid-run, then again at clear index 9.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ra_id = 4'd3;
    for (int e = 0; e < 9; e++) tick();
    @(negedge clk);
    chk1("mid-clear ready", ready, 1'b0);
    chk64("mid-clear ra_out", ra_out, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready(rise);
    chk64("restart latency", 64'(rise), 64'd16);

    // Old data and busy bits are gone after the restart.
    ra_id = 4'd7; rb_id = 4'd15;
    @(negedge clk);
    chk64("post-reset r7", ra_out, '0);
    chk64("post-reset r15", rb_out, '0);
    chk1("post-reset r7 busy", ra_busy, 1'b0);
    chk1("post-reset r15 busy", rb_busy, 1'b0);
    tick();
    ra_id = 4'd0; rb_id = 4'd3;
    @(negedge clk);
    chk64("post-reset r0", ra_out, '0);
    chk1("post-reset r0 busy", ra_busy, 1'b0);
    chk64("post-reset r3", rb_out, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
